// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch slice: default datapath and
// register-address widths, and the per-operand forwarding source select.
package operand_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  // Source of an EX-stage operand, lowest to highest priority.
  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Forwarding selector for one EX-stage source operand.
// Picks the youngest in-flight writer of the register (EX/MEM, then MEM/WB),
// falling back to the value latched at ID. x0 and unused operands never forward.
// Ports:
//   uses_i, rs_addr_i, latched_i         operand qualifier, address, ID/EX value
//   exmem_reg_write_i/exmem_rd_i/_result_i  MEM-stage writer
//   memwb_reg_write_i/memwb_rd_i/_result_i  WB-stage writer
//   operand_c                            selected operand (combinational)
module operand_fetch_fwd_mux #(
  parameter int unsigned XLEN = operand_fetch_pkg::XLEN,
  parameter int unsigned RA_W = operand_fetch_pkg::RA_W
) (
  input  logic            uses_i,
  input  logic [RA_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0] latched_i,
  input  logic            exmem_reg_write_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] operand_c
);

  import operand_fetch_pkg::*;

  fwd_sel_e fwd_sel;

  // Source selection: EX/MEM beats MEM/WB beats the latched register value.
  always_comb begin
    fwd_sel = FWD_REG;
    if (uses_i && (rs_addr_i != '0)) begin
      if (exmem_reg_write_i && (exmem_rd_i == rs_addr_i)) begin
        fwd_sel = FWD_EXMEM;
      end else if (memwb_reg_write_i && (memwb_rd_i == rs_addr_i)) begin
        fwd_sel = FWD_MEMWB;
      end
    end
  end

  // Operand steering.
  always_comb begin
    operand_c = latched_i;
    case (fwd_sel)
      FWD_EXMEM: operand_c = exmem_result_i;
      FWD_MEMWB: operand_c = memwb_result_i;
      default:   operand_c = latched_i;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// ID/EX operand fetch: register-file read with WB bypass, the ID/EX pipeline
// register, load-use stall detection and EX-stage operand forwarding.
// Ports:
//   clk, rst                         clock, async active-high reset
//   id_*                             decoded instruction from IF/ID
//   rf_rs*_addr / rf_rs*_data        register-file read port
//   exmem_* / memwb_*                in-flight writers for forwarding
//   flush                            kill the instruction entering EX
//   id_stall                         hold IF/ID and PC (combinational)
//   ex_*                             EX-stage instruction and operands
//   stall_count                      saturating load-use stall cycle count
module operand_fetch #(
  parameter int unsigned XLEN = operand_fetch_pkg::XLEN,
  parameter int unsigned RA_W = operand_fetch_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  output logic [RA_W-1:0] rf_rs1_addr,
  output logic [RA_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [31:0]     stall_count
);

  import operand_fetch_pkg::*;

  logic            valid_q, reg_write_q, is_load_q, uses_rs1_q, uses_rs2_q;
  logic [RA_W-1:0] rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_val_q, rs2_val_q;
  logic [XLEN-1:0] rs1_val_d, rs2_val_d;
  logic [31:0]     stall_count_q;
  logic            hazard_c;

  assign rf_rs1_addr = id_rs1_addr;
  assign rf_rs2_addr = id_rs2_addr;

  // The register file writes on the edge, so a same-cycle WB write is not yet
  // visible on the async read port; bypass it into the captured value.
  always_comb begin
    rs1_val_d = rf_rs1_data;
    rs2_val_d = rf_rs2_data;
    if (memwb_reg_write && (memwb_rd == id_rs1_addr) && (id_rs1_addr != '0)) begin
      rs1_val_d = memwb_result;
    end
    if (memwb_reg_write && (memwb_rd == id_rs2_addr) && (id_rs2_addr != '0)) begin
      rs2_val_d = memwb_result;
    end
  end

  // Load in EX whose result the ID instruction needs cannot be forwarded in time.
  always_comb begin
    hazard_c = valid_q && is_load_q && reg_write_q && (rd_q != '0) && id_valid &&
               ((id_uses_rs1 && (id_rs1_addr == rd_q)) ||
                (id_uses_rs2 && (id_rs2_addr == rd_q)));
  end

  assign id_stall = hazard_c && !flush;

  // ID/EX pipeline register; flush or stall inserts a bubble and leaves fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      uses_rs1_q  <= 1'b0;
      uses_rs2_q  <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
    end else if (flush || hazard_c) begin
      valid_q <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      reg_write_q <= id_reg_write;
      is_load_q   <= id_is_load;
      uses_rs1_q  <= id_uses_rs1;
      uses_rs2_q  <= id_uses_rs2;
      rd_q        <= id_rd_addr;
      rs1_q       <= id_rs1_addr;
      rs2_q       <= id_rs2_addr;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
    end
  end

  // Saturating load-use stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (id_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_reg_write = valid_q && reg_write_q;
  assign ex_is_load   = valid_q && is_load_q;
  assign ex_rd_addr   = rd_q;
  assign stall_count  = stall_count_q;

  operand_fetch_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .uses_i            (uses_rs1_q),
    .rs_addr_i         (rs1_q),
    .latched_i         (rs1_val_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_result_i    (memwb_result),
    .operand_c         (ex_rs1_data)
  );

  operand_fetch_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .uses_i            (uses_rs2_q),
    .rs_addr_i         (rs2_q),
    .latched_i         (rs2_val_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_result_i    (memwb_result),
    .operand_c         (ex_rs2_data)
  );

endmodule
